// File: rtl/sys_ctrl.sv
// System controller: decodes UART command bytes into register-file writes/reads
// and ALU operations, then streams read data or ALU results to the TX FIFO.
module sys_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  RX_P_DATA,
    input  logic        RX_D_VLD,
    input  logic [7:0]  RdData,
    input  logic        RdData_Valid,
    input  logic [15:0] ALU_OUT,
    input  logic        OUT_Valid,
    input  logic        FIFO_FULL,
    output logic        WrEn,
    output logic        RdEn,
    output logic [3:0]  Address,
    output logic [7:0]  WrData,
    output logic        ALU_EN,
    output logic [3:0]  ALU_FUN,
    output logic        CLK_GATE_EN,
    output logic [7:0]  TX_P_DATA,
    output logic        TX_D_VLD
);

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned RW = 16;

    localparam logic [DW-1:0] CMD_WR  = 8'hAA;
    localparam logic [DW-1:0] CMD_RD  = 8'hBB;
    localparam logic [DW-1:0] CMD_ALU = 8'hCC;
    localparam logic [DW-1:0] CMD_FUN = 8'hDD;

    localparam logic [AW-1:0] OPA_ADDR = 4'h0;
    localparam logic [AW-1:0] OPB_ADDR = 4'h1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_OP_A,
        S_OP_B,
        S_OP_FUN,
        S_FUN_ONLY,
        S_ALU_WAIT,
        S_TX_RD,
        S_TX_LO,
        S_TX_HI
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_rd_data;
    logic [RW-1:0]   r_alu_out;

    // Single registered FSM: strobes default low every cycle, data outputs hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rd_data   <= '0;
            r_alu_out   <= '0;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            Address     <= '0;
            WrData      <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
        end else begin
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            ALU_EN   <= 1'b0;
            TX_D_VLD <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            CMD_WR:  r_state <= S_WR_ADDR;
                            CMD_RD:  r_state <= S_RD_ADDR;
                            CMD_ALU: r_state <= S_OP_A;
                            CMD_FUN: begin
                                r_state     <= S_FUN_ONLY;
                                CLK_GATE_EN <= 1'b1;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end

                S_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_DATA[AW-1:0];
                        r_state <= S_WR_DATA;
                    end
                end

                S_WR_DATA: begin
                    if (RX_D_VLD) begin
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                S_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_DATA[AW-1:0];
                        RdEn    <= 1'b1;
                        r_state <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    if (RdData_Valid) begin
                        r_rd_data <= RdData;
                        r_state   <= S_TX_RD;
                    end
                end

                S_OP_A: begin
                    if (RX_D_VLD) begin
                        Address <= OPA_ADDR;
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        r_state <= S_OP_B;
                    end
                end

                // Gate opens on entry to OP_FUN so the ALU clock is live before ALU_EN.
                S_OP_B: begin
                    if (RX_D_VLD) begin
                        Address     <= OPB_ADDR;
                        WrData      <= RX_P_DATA;
                        WrEn        <= 1'b1;
                        CLK_GATE_EN <= 1'b1;
                        r_state     <= S_OP_FUN;
                    end
                end

                S_OP_FUN, S_FUN_ONLY: begin
                    if (RX_D_VLD) begin
                        ALU_FUN <= RX_P_DATA[AW-1:0];
                        ALU_EN  <= 1'b1;
                        r_state <= S_ALU_WAIT;
                    end
                end

                S_ALU_WAIT: begin
                    if (OUT_Valid) begin
                        r_alu_out   <= ALU_OUT;
                        CLK_GATE_EN <= 1'b0;
                        r_state     <= S_TX_LO;
                    end
                end

                S_TX_RD: begin
                    if (!FIFO_FULL) begin
                        TX_P_DATA <= r_rd_data;
                        TX_D_VLD  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                S_TX_LO: begin
                    if (!FIFO_FULL) begin
                        TX_P_DATA <= r_alu_out[DW-1:0];
                        TX_D_VLD  <= 1'b1;
                        r_state   <= S_TX_HI;
                    end
                end

                S_TX_HI: begin
                    if (!FIFO_FULL) begin
                        TX_P_DATA <= r_alu_out[RW-1:DW];
                        TX_D_VLD  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: directed command scenarios plus randomized traffic, all
// checked every cycle against a command-level reference model.
module tb_sys_ctrl;

    localparam int unsigned HALF      = 5;
    localparam int unsigned N_RANDOM  = 4000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        OUT_Valid = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic        WrEn;
    logic        RdEn;
    logic [3:0]  Address;
    logic [7:0]  WrData;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;

    int n_cmp = 0;
    int n_err = 0;

    sys_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .ALU_OUT      (ALU_OUT),
        .OUT_Valid    (OUT_Valid),
        .FIFO_FULL    (FIFO_FULL),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .ALU_EN       (ALU_EN),
        .ALU_FUN      (ALU_FUN),
        .CLK_GATE_EN  (CLK_GATE_EN),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD)
    );

    always #HALF clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the open command and its argument bytes,
    // outstanding read/ALU results, and a queue of bytes owed to the TX FIFO.
    logic [7:0] m_cmd = '0;
    bit         m_cmd_vld = 1'b0;
    logic [7:0] m_args[$];
    bit         m_wait_rd = 1'b0;
    bit         m_wait_alu = 1'b0;
    logic [7:0] m_txq[$];

    logic       e_wren = 1'b0;
    logic       e_rden = 1'b0;
    logic [3:0] e_addr = '0;
    logic [7:0] e_wrdata = '0;
    logic       e_aluen = 1'b0;
    logic [3:0] e_alufun = '0;
    logic       e_gate = 1'b0;
    logic [7:0] e_txdata = '0;
    logic       e_txvld = 1'b0;

    task automatic model_reset();
        m_cmd_vld = 1'b0;
        m_args.delete();
        m_txq.delete();
        m_wait_rd = 1'b0;
        m_wait_alu = 1'b0;
        e_wren = 1'b0; e_rden = 1'b0; e_addr = '0; e_wrdata = '0;
        e_aluen = 1'b0; e_alufun = '0; e_gate = 1'b0; e_txdata = '0; e_txvld = 1'b0;
    endtask

    task automatic start_alu(input logic [7:0] b);
        e_alufun = b[3:0];
        e_aluen = 1'b1;
        m_wait_alu = 1'b1;
        m_cmd_vld = 1'b0;
    endtask

    task automatic take_arg(input logic [7:0] b);
        int n;
        m_args.push_back(b);
        n = m_args.size();
        case (m_cmd)
            8'hAA: begin
                if (n == 1) e_addr = b[3:0];
                else begin
                    e_wrdata = b; e_wren = 1'b1; m_cmd_vld = 1'b0;
                end
            end
            8'hBB: begin
                e_addr = b[3:0]; e_rden = 1'b1; m_wait_rd = 1'b1; m_cmd_vld = 1'b0;
            end
            8'hCC: begin
                if (n <= 2) begin
                    e_addr = 4'(n - 1); e_wrdata = b; e_wren = 1'b1;
                    if (n == 2) e_gate = 1'b1;
                end else start_alu(b);
            end
            default: start_alu(b);
        endcase
    endtask

    task automatic model_step();
        logic [7:0] b;
        e_wren = 1'b0; e_rden = 1'b0; e_aluen = 1'b0; e_txvld = 1'b0;
        if (m_txq.size() != 0) begin
            if (!FIFO_FULL) begin
                e_txdata = m_txq.pop_front();
                e_txvld = 1'b1;
            end
        end else if (m_wait_rd) begin
            if (RdData_Valid) begin
                m_txq.push_back(RdData);
                m_wait_rd = 1'b0;
            end
        end else if (m_wait_alu) begin
            if (OUT_Valid) begin
                m_txq.push_back(ALU_OUT[7:0]);
                m_txq.push_back(ALU_OUT[15:8]);
                m_wait_alu = 1'b0;
                e_gate = 1'b0;
            end
        end else if (RX_D_VLD) begin
            b = RX_P_DATA;
            if (!m_cmd_vld) begin
                if (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) begin
                    m_cmd = b;
                    m_cmd_vld = 1'b1;
                    m_args.delete();
                    if (b == 8'hDD) e_gate = 1'b1;
                end
            end else begin
                take_arg(b);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("WrEn",        16'(WrEn),        16'(e_wren));
        chk("RdEn",        16'(RdEn),        16'(e_rden));
        chk("Address",     16'(Address),     16'(e_addr));
        chk("WrData",      16'(WrData),      16'(e_wrdata));
        chk("ALU_EN",      16'(ALU_EN),      16'(e_aluen));
        chk("ALU_FUN",     16'(ALU_FUN),     16'(e_alufun));
        chk("CLK_GATE_EN", 16'(CLK_GATE_EN), 16'(e_gate));
        chk("TX_P_DATA",   16'(TX_P_DATA),   16'(e_txdata));
        chk("TX_D_VLD",    16'(TX_D_VLD),    16'(e_txvld));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD = 1'b1;
        tick();
        RX_D_VLD = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_zero_strobes"}, 16'({WrEn, RdEn, ALU_EN, TX_D_VLD, CLK_GATE_EN}), 16'h0);
        chk({tag, "_zero_addr"},    16'(Address),   16'h0);
        chk({tag, "_zero_wrdata"},  16'(WrData),    16'h0);
        chk({tag, "_zero_alufun"},  16'(ALU_FUN),   16'h0);
        chk({tag, "_zero_txdata"},  16'(TX_P_DATA), 16'h0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Write: AA 05 3C
        send_byte(8'hAA);
        send_byte(8'h05);
        chk("wr_addr_latched", 16'(Address), 16'h5);
        chk("wr_no_early_wren", 16'(WrEn), 16'h0);
        send_byte(8'h3C);
        chk("wr_wren", 16'(WrEn), 16'h1);
        chk("wr_addr", 16'(Address), 16'h5);
        chk("wr_data", 16'(WrData), 16'h3C);
        tick();
        chk("wr_wren_one_cycle", 16'(WrEn), 16'h0);

        // Read: BB 07, RdData 5A
        send_byte(8'hBB);
        send_byte(8'h07);
        chk("rd_rden", 16'(RdEn), 16'h1);
        chk("rd_addr", 16'(Address), 16'h7);
        RdData = 8'h5A;
        RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        chk("rd_rden_one_cycle", 16'(RdEn), 16'h0);
        tick();
        chk("rd_tx_vld", 16'(TX_D_VLD), 16'h1);
        chk("rd_tx_data", 16'(TX_P_DATA), 16'h5A);
        tick();
        chk("rd_tx_one_cycle", 16'(TX_D_VLD), 16'h0);

        // ALU: CC 12 34 02, result BEEF with 10 cycles of backpressure
        send_byte(8'hCC);
        chk("alu_gate_off_opa", 16'(CLK_GATE_EN), 16'h0);
        send_byte(8'h12);
        chk("alu_opa_wr", 16'({WrEn, Address, WrData}), 16'({1'b1, 4'h0, 8'h12}));
        send_byte(8'h34);
        chk("alu_opb_wr", 16'({WrEn, Address, WrData}), 16'({1'b1, 4'h1, 8'h34}));
        chk("alu_gate_on", 16'(CLK_GATE_EN), 16'h1);
        send_byte(8'h02);
        chk("alu_en", 16'(ALU_EN), 16'h1);
        chk("alu_fun", 16'(ALU_FUN), 16'h2);
        send_byte(8'hAA);
        chk("alu_wait_drop_rx", 16'({WrEn, RdEn, ALU_EN}), 16'h0);
        chk("alu_gate_hold", 16'(CLK_GATE_EN), 16'h1);
        tick();
        FIFO_FULL = 1'b1;
        ALU_OUT = 16'hBEEF;
        OUT_Valid = 1'b1;
        tick();
        OUT_Valid = 1'b0;
        chk("alu_gate_off_done", 16'(CLK_GATE_EN), 16'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_no_tx", 16'(TX_D_VLD), 16'h0);
        end
        FIFO_FULL = 1'b0;
        tick();
        chk("bp_tx_lo", 16'({TX_D_VLD, TX_P_DATA}), 16'({1'b1, 8'hEF}));
        tick();
        chk("bp_tx_hi", 16'({TX_D_VLD, TX_P_DATA}), 16'({1'b1, 8'hBE}));
        tick();
        chk("bp_tx_done", 16'(TX_D_VLD), 16'h0);

        // Illegal byte in IDLE: following bytes must not form a write
        send_byte(8'h55);
        send_byte(8'h05);
        send_byte(8'h3C);
        chk("illegal_no_wren", 16'(WrEn), 16'h0);

        // Function-only command: DD 09
        send_byte(8'hDD);
        chk("fun_gate_on", 16'(CLK_GATE_EN), 16'h1);
        send_byte(8'h09);
        chk("fun_alu", 16'({ALU_EN, ALU_FUN}), 16'({1'b1, 4'h9}));
        OUT_Valid = 1'b1;
        ALU_OUT = 16'h1234;
        tick();
        OUT_Valid = 1'b0;
        tick();
        chk("fun_tx_lo", 16'({TX_D_VLD, TX_P_DATA}), 16'({1'b1, 8'h34}));
        tick();
        chk("fun_tx_hi", 16'({TX_D_VLD, TX_P_DATA}), 16'({1'b1, 8'h12}));
        tick();

        // Reset mid-command
        send_byte(8'hAA);
        send_byte(8'h05);
        chk("rst_pre_addr", 16'(Address), 16'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'h3C);
        chk("rst_no_wren", 16'(WrEn), 16'h0);
        chk("rst_wrdata", 16'(WrData), 16'h0);
        tick();

        // Randomized traffic, including spurious valids and occasional resets
        for (int c = 0; c < N_RANDOM; c++) begin
            RX_D_VLD = ($urandom_range(0, 99) < 30);
            case ($urandom_range(0, 9))
                0:       RX_P_DATA = 8'hAA;
                1:       RX_P_DATA = 8'hBB;
                2:       RX_P_DATA = 8'hCC;
                3:       RX_P_DATA = 8'hDD;
                default: RX_P_DATA = 8'($urandom);
            endcase
            RdData_Valid = ($urandom_range(0, 99) < 15);
            RdData = 8'($urandom);
            OUT_Valid = ($urandom_range(0, 99) < 15);
            ALU_OUT = 16'($urandom);
            FIFO_FULL = ($urandom_range(0, 99) < 35);
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        RX_D_VLD = 1'b0;
        RdData_Valid = 1'b0;
        OUT_Valid = 1'b0;
        FIFO_FULL = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001: clk  in  1  single system clock; all state updates on rising edge.
REQ-002: rst_n  in  1  asynchronous, active-low reset.
REQ-003: RX_P_DATA  in  8  received byte from the UART receiver.
REQ-004: RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA valid in that cycle.
REQ-005: RdData  in  8  register-file read data.
REQ-006: RdData_Valid  in  1  one-cycle pulse; RdData valid in that cycle.
REQ-007: ALU_OUT  in  16  ALU result.
REQ-008: OUT_Valid  in  1  one-cycle pulse; ALU_OUT valid in that cycle.
REQ-009: FIFO_FULL  in  1  TX FIFO cannot accept a byte this cycle.
REQ-010: WrEn, RdEn  out  1 each  register-file write/read strobe, one cycle.
REQ-011: Address  out  4  register-file address.
REQ-012: WrData  out  8  register-file write data.
REQ-013: ALU_EN  out  1  one-cycle ALU start strobe.
REQ-014: ALU_FUN  out  4  ALU function select.
REQ-015: CLK_GATE_EN  out  1  enables the ALU clock gate.
REQ-016: TX_P_DATA  out  8  byte to the TX FIFO.
REQ-017: TX_D_VLD  out  1  one-cycle TX FIFO write strobe.

Function
REQ-018: All outputs registered; each strobe lasts exactly one clk cycle.
REQ-019: States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FUN, FUN_ONLY, ALU_WAIT, TX_RD, TX_LO, TX_HI.
REQ-020: IDLE, on RX_D_VLD: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OP_A, 0xDD->FUN_ONLY; any other byte is discarded and the block stays in IDLE.
REQ-021: WR_ADDR: on RX_D_VLD latch RX_P_DATA[3:0] into Address -> WR_DATA.
REQ-022: WR_DATA: on RX_D_VLD, WrData=RX_P_DATA and WrEn=1 in the next cycle -> IDLE.
REQ-023: RD_ADDR: on RX_D_VLD, Address=RX_P_DATA[3:0] and RdEn=1 in the next cycle -> RD_WAIT.
REQ-024: RD_WAIT: on RdData_Valid latch RdData -> TX_RD; the block waits indefinitely otherwise.
REQ-025: OP_A/OP_B: on RX_D_VLD write the byte to register address 0x0 (OP_A) / 0x1 (OP_B) via WrEn; OP_A->OP_B->OP_FUN.
REQ-026: OP_FUN/FUN_ONLY: on RX_D_VLD, ALU_FUN=RX_P_DATA[3:0] and ALU_EN=1 in the next cycle -> ALU_WAIT.
REQ-027: CLK_GATE_EN=1 from entry to OP_FUN/FUN_ONLY until exit from ALU_WAIT; 0 elsewhere.
REQ-028: ALU_WAIT: on OUT_Valid latch ALU_OUT -> TX_LO.
REQ-029: TX_RD/TX_LO/TX_HI: while FIFO_FULL=1, hold the state with TX_D_VLD=0; when FIFO_FULL=0, drive TX_P_DATA (read byte / ALU_OUT[7:0] / ALU_OUT[15:8]) with TX_D_VLD=1 for one cycle.
REQ-030: After TX_RD -> IDLE; after TX_LO -> TX_HI; after TX_HI -> IDLE.
REQ-031: RX_D_VLD received in RD_WAIT, ALU_WAIT or any TX state is dropped without effect.
REQ-032: Address, WrData, ALU_FUN and TX_P_DATA hold their last value between strobes.
REQ-033: RdData_Valid/OUT_Valid outside their wait states are ignored.

Reset
REQ-034: rst_n=0 forces IDLE immediately; all outputs 0; latched data registers 0.
REQ-035: Reset asserted mid-command abandons the command; no strobe is issued after release until a new command byte arrives.

Verification
REQ-036: Write: RX bytes AA,05,3C -> single WrEn pulse with Address=5, WrData=0x3C; return to IDLE.
REQ-037: Read: RX bytes BB,07; RdData_Valid with RdData=0x5A -> RdEn pulse with Address=7, then TX_D_VLD pulse with TX_P_DATA=0x5A.
REQ-038: ALU: RX bytes CC,12,34,02; OUT_Valid with ALU_OUT=0xBEEF -> WrEn at addresses 0 and 1, ALU_EN pulse with ALU_FUN=2, TX bytes EF then BE; CLK_GATE_EN=1 only during the operation.
REQ-039: Backpressure: FIFO_FULL=1 for 10 cycles during TX_LO -> no TX_D_VLD for those 10 cycles; EF is sent on release, then BE.
REQ-040: Illegal/robustness: byte 0x55 in IDLE -> no strobes; RX byte during ALU_WAIT dropped; rst_n pulse after AA,05 -> outputs 0, then a following 0x3C produces no WrEn.
